alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the 8-bit ALU operand/select interface. Accepts operation commands over a valid/ready handshake and drives registered A, B and select onto the combinational ALU. After a fixed settle time it captures the ALU result and carry, then returns them with status flags over a second valid/ready handshake. An internal accumulator lets a command chain on the previous result.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
SETTLE_CYCLES, 1, cycles alu_* are held before the result is sampled; legal range 1..15.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  ALU select code
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_chain  in  1  use the accumulator instead of cmd_a as A
acc_clr  in  1  synchronous accumulator invalidate
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_sel  out  4  to ALU select
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry-out (always the carry of A+B)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  carry; valid for op 0000 only
rsp_zero  out  1  rsp_result == 0
rsp_err  out  1  divide by zero
ops_done  out  CNT_W  count of completed responses
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE.
  - All registered outputs go to 0: alu_*, rsp_*, ops_done.
  - Accumulator goes to 0; acc_valid goes to 0.
  - cmd_ready = 1, because cmd_ready is decoded from state == IDLE. busy = 0.
- States are IDLE, DRIVE and RESP.
- IDLE:
  - cmd_ready = 1.
  - On a cmd_valid & cmd_ready edge:
    - alu_sel <= cmd_op.
    - alu_b <= cmd_b.
    - alu_a <= acc if (cmd_chain & acc_valid), else cmd_a. cmd_chain with acc_valid = 0 silently uses cmd_a.
    - Load the settle counter with SETTLE_CYCLES and go to DRIVE.
- DRIVE:
  - cmd_ready = 0; alu_* held stable.
  - The counter decrements every cycle. DRIVE lasts exactly SETTLE_CYCLES cycles.
  - On the edge ending the last DRIVE cycle, go to RESP and capture:
    - rsp_result <= alu_out.
    - rsp_carry <= alu_carry if alu_sel == 0000, else 0.
    - rsp_zero <= (captured result == 0).
    - rsp_err <= 0.
    - rsp_valid <= 1.
- Divide by zero (alu_sel == 0011 and alu_b == 0):
  - Same timing as any other op; alu_out is ignored.
  - rsp_result = all ones (0xFF), rsp_err = 1, rsp_carry = 0, rsp_zero = 0.
- RESP:
  - rsp_valid = 1. rsp_* and alu_* are held stable until the handshake; cmd_valid is ignored (cmd_ready = 0).
  - On a rsp_valid & rsp_ready edge:
    - rsp_valid <= 0; state goes to IDLE.
    - ops_done increments, wrapping from 2^CNT_W-1 to 0.
    - If rsp_err = 0: acc <= rsp_result and acc_valid <= 1.
    - If rsp_err = 1: acc and acc_valid are unchanged.
  - rsp_result and flags hold their last values after the handshake.
- Latency:
  - Command accepted at edge E; rsp_valid is high from edge E+SETTLE_CYCLES.
  - Minimum command spacing is SETTLE_CYCLES+2 cycles: one mandatory IDLE cycle after each handshake, no overlap.
- acc_clr:
  - Clears acc_valid in any state.
  - If asserted on the same edge as a RESP handshake, the clear wins: acc_valid = 0.
- Reset mid-operation: the operation is aborted, no response is produced, and ops_done is not incremented.
- Arithmetic is entirely inside the ALU; the sequencer only masks carry and computes zero/err.

Test Plan:
1. SETTLE_CYCLES=1; cmd op=0000, a=0x0A, b=0x02, accepted at edge E.
   - Expect alu_a=0x0A, alu_b=0x02, alu_sel=0000 after E.
   - Expect rsp_valid from E+1 with result 0x0C, carry 0, zero 0, err 0.
2. cmd op=0000, a=0xF6, b=0x0A.
   - Expect result 0x00, carry 1, zero 1.
   - Repeat with op=1000 (AND): result 0x02, carry 0 even though ALU carry = 1.
3. Chain: complete 0x0A+0x02=0x0C, then cmd op=0001, chain=1, a=0x55, b=0x04.
   - Expect alu_a=0x0C and result 0x08.
   - Then acc_clr, then chain cmd op=0000, a=0x01, b=0x01: expect alu_a=0x01, result 0x02.
4. cmd op=0011, a=0x0A, b=0x00.
   - Expect result 0xFF, err 1, ops_done incremented.
   - Next chain command still uses the prior accumulator value.
5. Backpressure: hold rsp_ready=0 for 5 cycles while toggling cmd_valid.
   - Expect rsp_valid and all rsp_*/alu_* stable, cmd_ready 0, no command accepted.
   - rsp_ready=1 then completes the handshake, and cmd_ready rises the next cycle.
6. SETTLE_CYCLES=4; assert rst_n=0 on the second DRIVE cycle.
   - Expect all outputs 0 immediately, state IDLE, no response.
   - After release, chain cmd a=0x03, b=0x04, op=0000 uses cmd_a: result 0x07, ops_done=1 after its handshake.
   - Also run 256 ops with CNT_W=8 and check ops_done wraps to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU operand/select initiator with result capture and accumulator chaining
//
// Purpose: accepts ALU commands over a valid/ready handshake, drives registered
// operands and select onto a combinational ALU, waits SETTLE_CYCLES, captures
// the result with carry/zero/error flags and returns it over a second handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        ALU select and operands
//   cmd_chain                   take operand A from the accumulator when it is valid
//   acc_clr                     invalidate the accumulator
//   alu_a, alu_b, alu_sel       registered drive to the ALU
//   alu_out, alu_carry          ALU result and carry of A+B
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_carry,
//   rsp_zero, rsp_err           captured result and flags
//   ops_done                    completed-response counter (wraps)
//   busy                        sequencer not idle

module alu_op_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] acc;
    logic             acc_valid;

    logic             cmd_fire;
    logic             capture;
    logic             rsp_fire;
    logic             div_zero;
    logic [WIDTH-1:0] result_next;

    // Divide by zero is decided by the sequencer itself; the ALU output is
    // not trusted in that case and is replaced by all ones.
    assign div_zero    = (alu_sel == OP_DIV) && (alu_b == '0);
    assign result_next = div_zero ? '1 : alu_out;
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        cmd_fire   = 1'b0;
        capture    = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                // Counter was loaded with SETTLE_CYCLES, so reaching 1 marks
                // the last cycle the ALU inputs have been held.
                if (settle_cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            ops_done   <= '0;
            acc        <= '0;
            acc_valid  <= 1'b0;
        end else begin
            state <= state_next;

            if (cmd_fire) begin
                alu_sel    <= cmd_op;
                alu_b      <= cmd_b;
                alu_a      <= (cmd_chain && acc_valid) ? acc : cmd_a;
                settle_cnt <= 4'(SETTLE_CYCLES);
            end else if (state == DRIVE) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                rsp_result <= result_next;
                // Carry is only meaningful for the add operation.
                rsp_carry  <= (alu_sel == OP_ADD) && alu_carry;
                rsp_zero   <= (result_next == '0);
                rsp_err    <= div_zero;
                rsp_valid  <= 1'b1;
            end

            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + CNT_W'(1);
                if (!rsp_err) begin
                    acc       <= rsp_result;
                    acc_valid <= 1'b1;
                end
            end

            // Placed last so a clear on the handshake edge wins.
            if (acc_clr) begin
                acc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer (settle 1 and settle 4 instances)

module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n      [2];
    logic       cmd_valid  [2];
    logic       cmd_ready  [2];
    logic [3:0] cmd_op     [2];
    logic [7:0] cmd_a      [2];
    logic [7:0] cmd_b      [2];
    logic       cmd_chain  [2];
    logic       acc_clr    [2];
    logic [7:0] alu_a      [2];
    logic [7:0] alu_b      [2];
    logic [3:0] alu_sel    [2];
    wire  [7:0] alu_out    [2];
    wire        alu_carry  [2];
    logic       rsp_valid  [2];
    logic       rsp_ready  [2];
    logic [7:0] rsp_result [2];
    logic       rsp_carry  [2];
    logic       rsp_zero   [2];
    logic       rsp_err    [2];
    logic [7:0] ops_done   [2];
    logic       busy       [2];

    // Environment ALU: plain arithmetic on the selected operation.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return 8'(a + b);
            4'd1:    return 8'(a - b);
            4'd2:    return 8'(a * b);
            4'd3:    return (b != 0) ? 8'(a / b) : 8'h00;
            4'd8:    return a & b;
            4'd9:    return a | b;
            4'd10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic carry_f(input logic [7:0] a, input logic [7:0] b);
        return (32'(a) + 32'(b)) > 255;
    endfunction

    function automatic int settle_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_out[g]   = alu_f(alu_sel[g], alu_a[g], alu_b[g]);
        assign alu_carry[g] = carry_f(alu_a[g], alu_b[g]);

        alu_op_sequencer #(
            .WIDTH(8),
            .SETTLE_CYCLES((g == 0) ? 1 : 4),
            .CNT_W(8)
        ) dut (
            .clk(clk),
            .rst_n(rst_n[g]),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op[g]),
            .cmd_a(cmd_a[g]),
            .cmd_b(cmd_b[g]),
            .cmd_chain(cmd_chain[g]),
            .acc_clr(acc_clr[g]),
            .alu_a(alu_a[g]),
            .alu_b(alu_b[g]),
            .alu_sel(alu_sel[g]),
            .alu_out(alu_out[g]),
            .alu_carry(alu_carry[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_result(rsp_result[g]),
            .rsp_carry(rsp_carry[g]),
            .rsp_zero(rsp_zero[g]),
            .rsp_err(rsp_err[g]),
            .ops_done(ops_done[g]),
            .busy(busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_acc       [2];
    logic       m_acc_valid [2];
    int         m_ops       [2];
    logic [7:0] e_a, e_b, e_res;
    logic [3:0] e_op;
    logic       e_carry, e_zero, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_acc[u]       = 8'h00;
        m_acc_valid[u] = 1'b0;
        m_ops[u]       = 0;
    endtask

    // Called and returns at a falling edge. Presents one command, checks the
    // ALU drive, the response latency and the response contents.
    task automatic issue(input int u, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic chain);
        int n;
        n = 0;
        while (!cmd_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready[u], 1);
        e_a  = (chain && m_acc_valid[u]) ? m_acc[u] : a;
        e_b  = b;
        e_op = op;
        if (op == 4'd3 && b == 8'h00) begin
            e_res   = 8'hFF;
            e_err   = 1'b1;
            e_carry = 1'b0;
        end else begin
            e_res   = alu_f(op, e_a, b);
            e_err   = 1'b0;
            e_carry = (op == 4'd0) ? carry_f(e_a, b) : 1'b0;
        end
        e_zero = (e_res == 8'h00);
        cmd_valid[u] = 1'b1;
        cmd_op[u]    = op;
        cmd_a[u]     = a;
        cmd_b[u]     = b;
        cmd_chain[u] = chain;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[u] = 1'b0;
        cmd_chain[u] = 1'b0;
        check("alu_a", alu_a[u], e_a);
        check("alu_b", alu_b[u], e_b);
        check("alu_sel", alu_sel[u], e_op);
        check("busy_drive", busy[u], 1);
        n = 0;
        while (!rsp_valid[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, settle_of(u));
        check("rsp_result", rsp_result[u], e_res);
        check("rsp_carry", rsp_carry[u], e_carry);
        check("rsp_zero", rsp_zero[u], e_zero);
        check("rsp_err", rsp_err[u], e_err);
    endtask

    task automatic finish_rsp(input int u, input logic clr);
        rsp_ready[u] = 1'b1;
        acc_clr[u]   = clr;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        acc_clr[u]   = 1'b0;
        m_ops[u]++;
        if (!e_err) begin
            m_acc[u]       = e_res;
            m_acc_valid[u] = 1'b1;
        end
        if (clr) m_acc_valid[u] = 1'b0;
        check("rsp_valid_drop", rsp_valid[u], 0);
        check("cmd_ready_after", cmd_ready[u], 1);
        check("ops_done", ops_done[u], 32'(m_ops[u] % 256));
        check("rsp_result_hold", rsp_result[u], e_res);
    endtask

    task automatic clear_acc(input int u);
        acc_clr[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_clr[u] = 1'b0;
        m_acc_valid[u] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; cmd_valid[u] = 1'b0; cmd_op[u] = 4'd0;
            cmd_a[u] = 8'h00; cmd_b[u] = 8'h00; cmd_chain[u] = 1'b0;
            acc_clr[u] = 1'b0; rsp_ready[u] = 1'b0;
            model_reset(u);
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_cmd_ready", cmd_ready[u], 1);
            check("rst_busy", busy[u], 0);
            check("rst_rsp_valid", rsp_valid[u], 0);
            check("rst_ops_done", ops_done[u], 0);
            check("rst_alu", {alu_a[u], alu_b[u], alu_sel[u]}, 0);
            check("rst_rsp", {rsp_result[u], rsp_carry[u], rsp_zero[u], rsp_err[u]}, 0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Basic add, carry/zero, AND masks carry
        issue(0, 4'd0, 8'h0A, 8'h02, 1'b0); finish_rsp(0, 1'b0);
        issue(0, 4'd0, 8'hF6, 8'h0A, 1'b0); finish_rsp(0, 1'b0);
        issue(0, 4'd8, 8'hF6, 8'h0A, 1'b0); finish_rsp(0, 1'b0);

        // Chaining and accumulator clear
        issue(0, 4'd0, 8'h0A, 8'h02, 1'b0); finish_rsp(0, 1'b0);
        issue(0, 4'd1, 8'h55, 8'h04, 1'b1); finish_rsp(0, 1'b0);
        check("chain_result", e_res, 8'h08);
        clear_acc(0);
        issue(0, 4'd0, 8'h01, 8'h01, 1'b1); finish_rsp(0, 1'b0);
        check("clr_chain_a", e_a, 8'h01);

        // Divide by zero leaves the accumulator alone
        issue(0, 4'd3, 8'h0A, 8'h00, 1'b0); finish_rsp(0, 1'b0);
        issue(0, 4'd0, 8'h11, 8'h01, 1'b1); finish_rsp(0, 1'b0);

        // Backpressure: response and drive held, commands ignored
        issue(0, 4'd9, 8'h30, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid[0] = i[0];
            cmd_a[0] = 8'($urandom);
            cmd_op[0] = 4'($urandom);
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid[0], 1);
            check("bp_cmd_ready", cmd_ready[0], 0);
            check("bp_rsp", {rsp_result[0], rsp_carry[0], rsp_zero[0], rsp_err[0]},
                  {e_res, e_carry, e_zero, e_err});
            check("bp_alu", {alu_a[0], alu_b[0], alu_sel[0]}, {e_a, e_b, e_op});
        end
        cmd_valid[0] = 1'b0;
        finish_rsp(0, 1'b0);

        // Clear on the same edge as the handshake wins
        issue(0, 4'd0, 8'h05, 8'h05, 1'b0); finish_rsp(0, 1'b1);
        issue(0, 4'd0, 8'h07, 8'h01, 1'b1); finish_rsp(0, 1'b0);
        check("clr_wins_a", e_a, 8'h07);

        // Settle 4 instance: normal op, then reset during the second DRIVE cycle
        issue(1, 4'd0, 8'h10, 8'h20, 1'b0); finish_rsp(1, 1'b0);
        cmd_valid[1] = 1'b1; cmd_op[1] = 4'd0; cmd_a[1] = 8'h40; cmd_b[1] = 8'h01;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check("abort_alu", {alu_a[1], alu_b[1], alu_sel[1]}, 0);
        check("abort_rsp_valid", rsp_valid[1], 0);
        check("abort_ops_done", ops_done[1], 0);
        check("abort_busy", busy[1], 0);
        check("abort_cmd_ready", cmd_ready[1], 1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        model_reset(1);
        repeat (6) @(negedge clk);
        check("abort_no_rsp", rsp_valid[1], 0);
        issue(1, 4'd0, 8'h03, 8'h04, 1'b1); finish_rsp(1, 1'b0);
        check("abort_chain_result", e_res, 8'h07);
        check("abort_ops_one", ops_done[1], 1);

        // 256 randomized operations from reset: counter must wrap to 0
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        model_reset(0);
        @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            logic [3:0] ops [8];
            logic [3:0] op;
            logic [7:0] b;
            ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd15};
            op = ops[$urandom_range(0, 7)];
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            issue(0, op, 8'($urandom), b, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            finish_rsp(0, ($urandom_range(0, 7) == 0));
        end
        check("ops_wrap", ops_done[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
